zap_mem_arbiter: RTL and testbench
==================================

// Module: zap_mem_arbiter
// PURPOSE
//  Shares one external RAM port between the instruction-side and data-side
//  memory paths of the ZAP core. Sits between the two MMU/cache memory ports
//  and the single SoC memory bus. Requests are registered onto the bus, the
//  bus stall is waited out, then the result is returned to the winning side.
//  Data side has priority; an anti-starvation counter bounds I-side latency.
// PARAMETERS
//  STARVE_LIMIT  8   consecutive D grants while I waits before I wins once
// PORTS
//  i_clk         in   1   clock; single clock domain
//  i_reset       in   1   reset; asynchronous, active-high
//  i_d_rd_en     in   1   D read request, held until o_d_stall=0
//  i_d_wr_en     in   1   D write request, held until o_d_stall=0
//  i_d_addr      in   32  D address
//  i_d_wdata     in   32  D write data
//  i_d_ben       in   4   D byte enables
//  o_d_rdata     out  32  D read data, valid when o_d_stall=0 after a read
//  o_d_stall     out  1   D request not yet complete
//  i_i_rd_en     in   1   I read request, held until o_i_stall=0 or flush
//  i_i_addr      in   32  I address
//  i_i_flush     in   1   abandon outstanding I request (pipeline clear)
//  o_i_rdata     out  32  I read data, valid when o_i_stall=0
//  o_i_stall     out  1   I request not yet complete
//  o_ram_rd_en   out  1   RAM read command (registered)
//  o_ram_wr_en   out  1   RAM write command (registered)
//  o_ram_addr    out  32  RAM address (registered)
//  o_ram_data    out  32  RAM write data (registered)
//  o_ram_ben     out  4   RAM byte enables (registered; 4'hF on I reads)
//  i_ram_data    in   32  RAM read data, valid when i_ram_stall=0
//  i_ram_stall   in   1   RAM busy; command held while high
// BEHAVIOUR
//  Reset: state=IDLE; all o_ram_* = 0; o_d_rdata=o_i_rdata=0; starve_cnt=0;
//   discard=0. o_*_stall follow the combinational rule below from reset.
//  States: IDLE, BUSY_D, BUSY_I, DONE_D, DONE_I.
//  IDLE: d_req=rd|wr. If d_req and (!i_i_rd_en or starve_cnt<STARVE_LIMIT)
//   -> latch D cmd onto o_ram_*, BUSY_D. Else if i_i_rd_en and !i_i_flush
//   -> latch I cmd (rd_en=1, wr_en=0, ben=F, data=0), BUSY_I. Else stay.
//  d_rd_en and d_wr_en both high: write wins; read ignored (checker flags).
//  BUSY_x: hold o_ram_* stable while i_ram_stall=1. When i_ram_stall=0:
//   drop o_ram_rd_en/wr_en, capture i_ram_data into o_x_rdata (reads only),
//   go DONE_x; from BUSY_I with discard=1 go IDLE, clear discard, no capture.
//  DONE_x: one cycle; requester samples data; next state IDLE.
//  o_d_stall = d_req & (state!=DONE_D); o_i_stall = i_i_rd_en & !i_i_flush
//   & (state!=DONE_I) — no request -> stall 0.
//  Minimum latency: request seen in IDLE at cycle N, RAM cmd N+1, RAM done
//   N+1 (zero-wait) -> DONE at N+2, stall low in cycle N+2.
//  Flush: i_i_flush in IDLE blocks I arbitration that cycle; in BUSY_I sets
//   discard (bus cycle still completes, result dropped); in DONE_I result
//   dropped (stall already 0 via flush term). Flush never affects D side.
//  Starvation: starve_cnt++ (saturating at STARVE_LIMIT) on each IDLE->BUSY_D
//   while i_i_rd_en=1; cleared on IDLE->BUSY_I. Counter width
//   $clog2(STARVE_LIMIT+1).
//  Back-to-back: no IDLE skip; each transaction costs >=1 IDLE cycle.
//  Async reset mid-transaction: all state and outputs return to reset
//   values immediately; in-flight RAM cycle is abandoned.
// TESTING
//  1 D read 0x100, RAM zero-wait, i_ram_data=0xDEADBEEF -> o_ram_rd_en
//    high 1 cyc, o_d_stall low 2 cyc after req, o_d_rdata=0xDEADBEEF.
//  2 D write 0x200 data 0x12345678 ben 4'b0011, i_ram_stall high 3 cyc ->
//    o_ram_* stable 4 cyc, o_d_stall drops in DONE_D, o_i_* untouched.
//  3 D and I requesting continuously, STARVE_LIMIT=8 -> 8 D grants then
//    exactly 1 I grant, pattern repeats; counter reset after I grant.
//  4 I read 0x40, i_ram_stall=1 for 5 cyc, i_i_flush pulse in cyc 2 ->
//    RAM read completes, o_i_rdata unchanged, FSM to IDLE, no DONE_I.
//  5 Assert i_reset while BUSY_D with stall high -> o_ram_rd_en/wr_en=0,
//    state IDLE same cycle; after release new D read serviced normally.
//  6 Simultaneous first-cycle D read and I read, starve_cnt=0 -> D first;
//    I serviced next; I stall low exactly once per request.

Source files
------------

// File: rtl/zap_mem_arbiter.sv
// Two-port arbiter for the ZAP core: the D side and the I side share one registered RAM port.
// D has priority, and a saturating starvation counter lets I win once after STARVE_LIMIT D grants.
module zap_mem_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_d_rd_en,
    input  logic        i_d_wr_en,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    input  logic [3:0]  i_d_ben,
    output logic [31:0] o_d_rdata,
    output logic        o_d_stall,
    input  logic        i_i_rd_en,
    input  logic [31:0] i_i_addr,
    input  logic        i_i_flush,
    output logic [31:0] o_i_rdata,
    output logic        o_i_stall,
    output logic        o_ram_rd_en,
    output logic        o_ram_wr_en,
    output logic [31:0] o_ram_addr,
    output logic [31:0] o_ram_data,
    output logic [3:0]  o_ram_ben,
    input  logic [31:0] i_ram_data,
    input  logic        i_ram_stall
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [2:0] {IDLE, BUSY_D, BUSY_I, DONE_D, DONE_I} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          discard_q, discard_d;
    logic          ram_rd_q, ram_rd_d, ram_wr_q, ram_wr_d;
    logic [31:0]   ram_addr_q, ram_addr_d, ram_data_q, ram_data_d;
    logic [3:0]    ram_ben_q, ram_ben_d;
    logic [31:0]   d_rdata_q, d_rdata_d, i_rdata_q, i_rdata_d;
    logic          d_req;

    assign d_req     = i_d_rd_en | i_d_wr_en;
    assign o_d_stall = d_req & (state_q != DONE_D);
    assign o_i_stall = i_i_rd_en & ~i_i_flush & (state_q != DONE_I);

    assign o_ram_rd_en = ram_rd_q;
    assign o_ram_wr_en = ram_wr_q;
    assign o_ram_addr  = ram_addr_q;
    assign o_ram_data  = ram_data_q;
    assign o_ram_ben   = ram_ben_q;
    assign o_d_rdata   = d_rdata_q;
    assign o_i_rdata   = i_rdata_q;

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        discard_d  = discard_q;
        ram_rd_d   = ram_rd_q;
        ram_wr_d   = ram_wr_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_ben_d  = ram_ben_q;
        d_rdata_d  = d_rdata_q;
        i_rdata_d  = i_rdata_q;
        case (state_q)
            IDLE: begin
                if (d_req && (!i_i_rd_en || starve_q < LIMIT)) begin
                    // A simultaneous read and write is treated as a write
                    ram_rd_d   = ~i_d_wr_en;
                    ram_wr_d   = i_d_wr_en;
                    ram_addr_d = i_d_addr;
                    ram_data_d = i_d_wdata;
                    ram_ben_d  = i_d_ben;
                    state_d    = BUSY_D;
                    if (i_i_rd_en && starve_q < LIMIT)
                        starve_d = starve_q + CW'(1);
                end else if (i_i_rd_en && !i_i_flush) begin
                    ram_rd_d   = 1'b1;
                    ram_wr_d   = 1'b0;
                    ram_addr_d = i_i_addr;
                    ram_data_d = 32'h0;
                    ram_ben_d  = 4'hF;
                    starve_d   = '0;
                    discard_d  = 1'b0;
                    state_d    = BUSY_I;
                end
            end
            BUSY_D: begin
                if (!i_ram_stall) begin
                    if (ram_rd_q)
                        d_rdata_d = i_ram_data;
                    ram_rd_d = 1'b0;
                    ram_wr_d = 1'b0;
                    state_d  = DONE_D;
                end
            end
            BUSY_I: begin
                if (i_i_flush)
                    discard_d = 1'b1;
                if (!i_ram_stall) begin
                    ram_rd_d = 1'b0;
                    ram_wr_d = 1'b0;
                    // A flushed fetch still finishes on the bus, but its data is dropped
                    if (discard_q || i_i_flush) begin
                        discard_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        i_rdata_d = i_ram_data;
                        state_d   = DONE_I;
                    end
                end
            end
            DONE_D, DONE_I: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            discard_q  <= 1'b0;
            ram_rd_q   <= 1'b0;
            ram_wr_q   <= 1'b0;
            ram_addr_q <= 32'h0;
            ram_data_q <= 32'h0;
            ram_ben_q  <= 4'h0;
            d_rdata_q  <= 32'h0;
            i_rdata_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            discard_q  <= discard_d;
            ram_rd_q   <= ram_rd_d;
            ram_wr_q   <= ram_wr_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ram_ben_q  <= ram_ben_d;
            d_rdata_q  <= d_rdata_d;
            i_rdata_q  <= i_rdata_d;
        end
    end

endmodule

// File: tb/tb_zap_mem_arbiter.sv
// Directed bench for zap_mem_arbiter: each scenario task drives its own stimulus.
// Expected values are worked out by hand from the arbitration and latency rules.
module tb_zap_mem_arbiter;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_d_rd_en = 1'b0, i_d_wr_en = 1'b0;
    logic [31:0] i_d_addr = 32'h0, i_d_wdata = 32'h0;
    logic [3:0]  i_d_ben = 4'h0;
    logic [31:0] o_d_rdata;
    logic        o_d_stall;
    logic        i_i_rd_en = 1'b0, i_i_flush = 1'b0;
    logic [31:0] i_i_addr = 32'h0;
    logic [31:0] o_i_rdata;
    logic        o_i_stall;
    logic        o_ram_rd_en, o_ram_wr_en;
    logic [31:0] o_ram_addr, o_ram_data;
    logic [3:0]  o_ram_ben;
    logic [31:0] i_ram_data = 32'h0;
    logic        i_ram_stall = 1'b0;

    int tests = 0;
    int fails = 0;

    zap_mem_arbiter #(.STARVE_LIMIT(8)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_d_rd_en(i_d_rd_en), .i_d_wr_en(i_d_wr_en), .i_d_addr(i_d_addr),
        .i_d_wdata(i_d_wdata), .i_d_ben(i_d_ben), .o_d_rdata(o_d_rdata),
        .o_d_stall(o_d_stall), .i_i_rd_en(i_i_rd_en), .i_i_addr(i_i_addr),
        .i_i_flush(i_i_flush), .o_i_rdata(o_i_rdata), .o_i_stall(o_i_stall),
        .o_ram_rd_en(o_ram_rd_en), .o_ram_wr_en(o_ram_wr_en), .o_ram_addr(o_ram_addr),
        .o_ram_data(o_ram_data), .o_ram_ben(o_ram_ben), .i_ram_data(i_ram_data),
        .i_ram_stall(i_ram_stall)
    );

    always #5 i_clk = ~i_clk;

    // Advance one clock and land 1ns after the rising edge
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic apply_reset();
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        #2;
        tests++;
        if ({o_ram_rd_en, o_ram_wr_en, o_ram_addr, o_ram_data, o_ram_ben} !== 70'h0) begin
            fails++;
            $display("FAIL reset_ram: rd=%b wr=%b addr=%h data=%h ben=%h, want all 0",
                     o_ram_rd_en, o_ram_wr_en, o_ram_addr, o_ram_data, o_ram_ben);
        end
        tests++;
        if ({o_d_rdata, o_i_rdata, o_d_stall, o_i_stall} !== 66'h0) begin
            fails++;
            $display("FAIL reset_outs: d_rdata=%h i_rdata=%h d_stall=%b i_stall=%b, want 0",
                     o_d_rdata, o_i_rdata, o_d_stall, o_i_stall);
        end
        i_d_rd_en = 1'b1;
        #1;
        tests++;
        if (o_d_stall !== 1'b1) begin
            fails++;
            $display("FAIL reset_dstall_comb: got %b want 1", o_d_stall);
        end
        i_d_rd_en = 1'b0;
        tick();
        i_reset = 1'b0;
        #1;
    endtask

    task automatic test_d_read();
        i_d_rd_en = 1'b1; i_d_addr = 32'h100; i_ram_stall = 1'b0; i_ram_data = 32'hDEADBEEF;
        #1;
        tests++;
        if (o_d_stall !== 1'b1) begin
            fails++;
            $display("FAIL dread_stall0: got %b want 1", o_d_stall);
        end
        tick();
        tests++;
        if (o_ram_rd_en !== 1'b1 || o_ram_wr_en !== 1'b0 || o_ram_addr !== 32'h100 || o_d_stall !== 1'b1) begin
            fails++;
            $display("FAIL dread_cmd: rd=%b wr=%b addr=%h stall=%b want 1 0 100 1",
                     o_ram_rd_en, o_ram_wr_en, o_ram_addr, o_d_stall);
        end
        tick();
        tests++;
        if (o_ram_rd_en !== 1'b0 || o_d_stall !== 1'b0 || o_d_rdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL dread_done: rd=%b stall=%b rdata=%h want 0 0 deadbeef",
                     o_ram_rd_en, o_d_stall, o_d_rdata);
        end
        i_d_rd_en = 1'b0;
        tick();
    endtask

    task automatic test_d_write_stall();
        i_d_wr_en = 1'b1; i_d_addr = 32'h200; i_d_wdata = 32'h12345678; i_d_ben = 4'b0011;
        i_ram_stall = 1'b1; i_ram_data = 32'hAAAA5555;
        for (int c = 1; c <= 3; c++) begin
            tick();
            tests++;
            if (o_ram_wr_en !== 1'b1 || o_ram_rd_en !== 1'b0 || o_ram_addr !== 32'h200 ||
                o_ram_data !== 32'h12345678 || o_ram_ben !== 4'b0011 || o_d_stall !== 1'b1) begin
                fails++;
                $display("FAIL dwrite_hold c%0d: wr=%b rd=%b addr=%h data=%h ben=%b stall=%b",
                         c, o_ram_wr_en, o_ram_rd_en, o_ram_addr, o_ram_data, o_ram_ben, o_d_stall);
            end
        end
        i_ram_stall = 1'b0;
        tick();
        tests++;
        if (o_ram_wr_en !== 1'b0 || o_d_stall !== 1'b0 || o_d_rdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL dwrite_done: wr=%b stall=%b d_rdata=%h want 0 0 deadbeef",
                     o_ram_wr_en, o_d_stall, o_d_rdata);
        end
        tests++;
        if (o_i_stall !== 1'b0 || o_i_rdata !== 32'h0) begin
            fails++;
            $display("FAIL dwrite_iside: i_stall=%b i_rdata=%h want 0 0", o_i_stall, o_i_rdata);
        end
        i_d_wr_en = 1'b0;
        tick();
    endtask

    task automatic test_i_flush();
        i_i_rd_en = 1'b1; i_i_addr = 32'h40; i_ram_stall = 1'b1; i_ram_data = 32'hCAFEF00D;
        #1;
        tests++;
        if (o_i_stall !== 1'b1) begin
            fails++;
            $display("FAIL flush_istall0: got %b want 1", o_i_stall);
        end
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 2) begin
                i_i_flush = 1'b1;
                #1;
                tests++;
                if (o_i_stall !== 1'b0) begin
                    fails++;
                    $display("FAIL flush_istall_flush: got %b want 0", o_i_stall);
                end
            end
            if (c == 3) begin
                i_i_flush = 1'b0;
                i_i_rd_en = 1'b0;
            end
            tests++;
            if (o_ram_rd_en !== 1'b1 || o_ram_addr !== 32'h40 || o_ram_ben !== 4'hF || o_ram_wr_en !== 1'b0) begin
                fails++;
                $display("FAIL flush_cmd_hold c%0d: rd=%b wr=%b addr=%h ben=%h want 1 0 40 f",
                         c, o_ram_rd_en, o_ram_wr_en, o_ram_addr, o_ram_ben);
            end
        end
        i_ram_stall = 1'b0;
        tick();
        tests++;
        if (o_ram_rd_en !== 1'b0 || o_i_rdata !== 32'h0) begin
            fails++;
            $display("FAIL flush_drop: rd=%b i_rdata=%h want 0 0", o_ram_rd_en, o_i_rdata);
        end
        // Already IDLE (no DONE_I), so a D request is granted on the very next edge
        i_d_rd_en = 1'b1; i_d_addr = 32'h900;
        tick();
        tests++;
        if (o_ram_rd_en !== 1'b1 || o_ram_addr !== 32'h900) begin
            fails++;
            $display("FAIL flush_no_done_i: rd=%b addr=%h want 1 900", o_ram_rd_en, o_ram_addr);
        end
        tick();
        i_d_rd_en = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        logic [31:0] seq[$];
        apply_reset();
        i_d_rd_en = 1'b1; i_d_addr = 32'h1000;
        i_i_rd_en = 1'b1; i_i_addr = 32'h2000;
        i_ram_stall = 1'b0; i_ram_data = 32'h0;
        for (int c = 0; c < 200 && seq.size() < 18; c++) begin
            tick();
            if (o_ram_rd_en)
                seq.push_back(o_ram_addr);
        end
        tests++;
        if (seq.size() != 18) begin
            fails++;
            $display("FAIL starve_timeout: got %0d grants want 18", seq.size());
        end
        for (int g = 0; g < seq.size(); g++) begin
            logic [31:0] exp_addr;
            exp_addr = (g % 9 == 8) ? 32'h2000 : 32'h1000;
            tests++;
            if (seq[g] !== exp_addr) begin
                fails++;
                $display("FAIL starve_grant%0d: addr=%h want %h", g, seq[g], exp_addr);
            end
        end
        i_d_rd_en = 1'b0; i_i_rd_en = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        i_d_wr_en = 1'b1; i_d_addr = 32'h300; i_d_wdata = 32'h77; i_d_ben = 4'hF; i_ram_stall = 1'b1;
        tick();
        tick();
        tests++;
        if (o_ram_wr_en !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_busy: wr=%b want 1", o_ram_wr_en);
        end
        i_reset = 1'b1;
        #1;
        tests++;
        if (o_ram_wr_en !== 1'b0 || o_ram_rd_en !== 1'b0 || o_ram_addr !== 32'h0 || o_d_stall !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_async: wr=%b rd=%b addr=%h d_stall=%b want 0 0 0 1",
                     o_ram_wr_en, o_ram_rd_en, o_ram_addr, o_d_stall);
        end
        i_d_wr_en = 1'b0; i_ram_stall = 1'b0;
        tick();
        i_reset = 1'b0;
        i_d_rd_en = 1'b1; i_d_addr = 32'h500; i_ram_data = 32'h55AA55AA;
        tick();
        tests++;
        if (o_ram_rd_en !== 1'b1 || o_ram_addr !== 32'h500) begin
            fails++;
            $display("FAIL rstmid_after_cmd: rd=%b addr=%h want 1 500", o_ram_rd_en, o_ram_addr);
        end
        tick();
        tests++;
        if (o_d_stall !== 1'b0 || o_d_rdata !== 32'h55AA55AA) begin
            fails++;
            $display("FAIL rstmid_after_done: stall=%b rdata=%h want 0 55aa55aa", o_d_stall, o_d_rdata);
        end
        i_d_rd_en = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int low_cnt;
        int low_at;
        apply_reset();
        low_cnt = 0; low_at = -1;
        i_d_rd_en = 1'b1; i_d_addr = 32'h600;
        i_i_rd_en = 1'b1; i_i_addr = 32'h700;
        i_ram_stall = 1'b0; i_ram_data = 32'h11111111;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 1) begin
                tests++;
                if (o_ram_addr !== 32'h600 || o_ram_rd_en !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_d_first: rd=%b addr=%h want 1 600", o_ram_rd_en, o_ram_addr);
                end
            end
            if (c == 2) begin
                tests++;
                if (o_d_rdata !== 32'h11111111 || o_d_stall !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b_d_done: rdata=%h stall=%b want 11111111 0", o_d_rdata, o_d_stall);
                end
                i_d_rd_en = 1'b0;
                i_ram_data = 32'h22222222;
            end
            if (c == 4) begin
                tests++;
                if (o_ram_addr !== 32'h700 || o_ram_rd_en !== 1'b1 || o_ram_ben !== 4'hF) begin
                    fails++;
                    $display("FAIL b2b_i_cmd: rd=%b addr=%h ben=%h want 1 700 f", o_ram_rd_en, o_ram_addr, o_ram_ben);
                end
            end
            if (o_i_stall == 1'b0) begin
                low_cnt++;
                low_at = c;
            end
        end
        tests++;
        if (low_cnt != 1 || low_at != 5 || o_i_rdata !== 32'h22222222) begin
            fails++;
            $display("FAIL b2b_i_once: low_cnt=%0d at=%0d i_rdata=%h want 1 5 22222222",
                     low_cnt, low_at, o_i_rdata);
        end
        i_i_rd_en = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_d_read();
        test_d_write_stall();
        test_i_flush();
        test_starvation();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
